// File: rtl/pc_subsys.sv
// Program-counter subsystem: holds the PC and selects increment, branch target or
// A-register value, loading on the falling clock edge when the branch/write enable allows.
module pc_subsys #(
   parameter int WIDTH    = 16,
   parameter int OFF_BITS = 12
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             PCWrite,
   input  logic             BEQCond,
   input  logic             BNECond,
   input  logic             zero,
   input  logic [1:0]       PCSource,
   input  logic [WIDTH-1:0] IRw,
   input  logic [WIDTH-1:0] aWire,
   output logic [WIDTH-1:0] PCw
);

   logic [WIDTH-1:0] pc_r;
   logic [WIDTH-1:0] next_pc_s;
   logic             en_s;

   // Write enable and next-PC selection
   always_comb begin
      en_s      = PCWrite | (BEQCond & zero) | (BNECond & ~zero);
      next_pc_s = pc_r;
      case (PCSource)
         2'b00:   next_pc_s = pc_r + {{(WIDTH-1){1'b0}}, 1'b1};
         2'b01:   next_pc_s = {pc_r[WIDTH-1:OFF_BITS], IRw[OFF_BITS-1:0]};
         2'b10:   next_pc_s = aWire;
         2'b11:   next_pc_s = pc_r;
         default: next_pc_s = pc_r;
      endcase
   end

   // PC register, updated on the falling edge so it is stable through the whole high phase
   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         pc_r <= {WIDTH{1'b0}};
      end else if (en_s) begin
         pc_r <= next_pc_s;
      end else begin
         pc_r <= pc_r;
      end
   end

   assign PCw = pc_r;

endmodule

// File: tb/tb_pc_subsys.sv
// Scoreboard bench for pc_subsys: directed steps push expected PC values, a monitor
// compares them against PCw in the following high phase.
module tb_pc_subsys;

   logic        clk;
   logic        reset;
   logic        PCWrite;
   logic        BEQCond;
   logic        BNECond;
   logic        zero;
   logic [1:0]  PCSource;
   logic [15:0] IRw;
   logic [15:0] aWire;
   logic [15:0] PCw;

   typedef struct {
      logic [15:0] val;
      string       tag;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp;
   int   n_err;

   pc_subsys #(.WIDTH(16), .OFF_BITS(12)) dut (
      .clk      (clk),
      .reset    (reset),
      .PCWrite  (PCWrite),
      .BEQCond  (BEQCond),
      .BNECond  (BNECond),
      .zero     (zero),
      .PCSource (PCSource),
      .IRw      (IRw),
      .aWire    (aWire),
      .PCw      (PCw)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: PCw=%h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   // Let n falling edges pass, then queue the PC value the monitor must see next high phase
   task automatic step(input int n, input logic [15:0] exp, input string tag);
      exp_t e;
      repeat (n) @(negedge clk);
      #1;
      e.val = exp;
      e.tag = tag;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare queued expectations in the high phase, away from the falling edge
   always @(posedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check(e.tag, PCw, e.val);
      end
   end

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      reset    = 1'b1;
      PCWrite  = 1'b1;
      BEQCond  = 1'b0;
      BNECond  = 1'b0;
      zero     = 1'b0;
      PCSource = 2'b00;
      IRw      = 16'h0000;
      aWire    = 16'h0000;
      @(posedge clk);
      #1;
      step(1, 16'h0000, "reset_hold_a");
      step(1, 16'h0000, "reset_hold_b");

      reset = 1'b0;
      for (int i = 1; i <= 11; i++) step(1, 16'(i), "increment");

      aWire    = 16'h0005;
      PCSource = 2'b10;
      step(1, 16'h0005, "jump_a");
      PCSource = 2'b00;
      step(1, 16'h0006, "inc_after_jump");
      step(4, 16'h000A, "inc_to_0a");

      PCWrite  = 1'b0;
      BEQCond  = 1'b1;
      zero     = 1'b1;
      PCSource = 2'b01;
      IRw      = 16'hFFC5;
      step(1, 16'h0FC5, "beq_taken");
      zero = 1'b0;
      IRw  = 16'h7777;
      for (int i = 0; i < 5; i++) step(1, 16'h0FC5, "beq_not_taken");
      BNECond = 1'b1;
      step(1, 16'h0777, "bne_taken");
      PCSource = 2'b11;
      step(1, 16'h0777, "src11_hold");

      PCSource = 2'b00;
      zero     = 1'b1;
      step(1, 16'h0778, "both_cond_zero1");
      zero = 1'b0;
      step(1, 16'h0779, "both_cond_zero0");

      BEQCond  = 1'b0;
      BNECond  = 1'b0;
      PCWrite  = 1'b1;
      aWire    = 16'hFFFF;
      PCSource = 2'b10;
      step(1, 16'hFFFF, "load_ffff");
      PCSource = 2'b00;
      step(1, 16'h0000, "wrap");
      aWire    = 16'hA123;
      PCSource = 2'b10;
      step(1, 16'hA123, "load_a123");
      PCSource = 2'b01;
      IRw      = 16'h0456;
      step(1, 16'hA456, "branch_upper_bits");

      PCWrite  = 1'b0;
      BNECond  = 1'b1;
      zero     = 1'b0;
      PCSource = 2'b00;
      step(1, 16'hA457, "cond_with_src00");
      BNECond = 1'b0;
      step(3, 16'hA457, "no_enable_hold");

      PCWrite  = 1'b1;
      aWire    = 16'h1234;
      PCSource = 2'b10;
      step(1, 16'h1234, "load_1234");
      @(negedge clk);
      #1;
      check("pre_async_reset", PCw, 16'h1234);
      #1;
      reset = 1'b1;
      #1;
      check("async_reset", PCw, 16'h0000);
      step(2, 16'h0000, "reset_held");
      reset    = 1'b0;
      PCSource = 2'b00;
      step(1, 16'h0001, "first_after_release");

      repeat (2) @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
